// File: rtl/imem_pkg.sv
// Shared definitions for the parametrised instruction-memory bank:
// FSM state encoding, boot image table and sizing helper.
package imem_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Widest word / address the image table can describe.
    localparam int MAX_W  = 64;
    localparam int MAX_AW = 16;

    // Image 1: small i281 demo program, repeats every 16 words on larger banks.
    localparam logic [15:0] IMAGE1 [16] = '{
        16'h8100, 16'h8201, 16'h2412, 16'h9300,
        16'hA003, 16'h3C12, 16'hD805, 16'hE402,
        16'h4507, 16'h1B2C, 16'hC0DE, 16'h7F01,
        16'h5A5A, 16'h6E0F, 16'hF00D, 16'h0FF0
    };

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Image 0 is all zeros; image 2 stores each word's own address.
    function automatic logic [MAX_W-1:0] image_word(input int sel,
                                                    input logic [MAX_AW-1:0] addr);
        logic [MAX_W-1:0] word;
        word = '0;
        case (sel)
            1:       word = MAX_W'(IMAGE1[addr[3:0]]);
            2:       word = MAX_W'(addr);
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/imem_init_rom.sv
// Combinational boot-image lookup: address -> image word for the selected
// program image.
module imem_init_rom
    import imem_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int WIDTH    = 16,
    parameter int INIT_SEL = 0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [WIDTH-1:0]  word
);

    assign word = WIDTH'(image_word(INIT_SEL, MAX_AW'(addr)));

endmodule

// File: rtl/imem_bank_param.sv
// Parametrised instruction-memory bank: boot loader copies an image in one
// word per cycle, then a valid/ready port programs single words.
module imem_bank_param
    import imem_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int INIT_SEL = 0
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] READ_SELECT,
    output logic [WIDTH-1:0]  IMEM_OUTPUT,
    input  logic [ADDR_W-1:0] WRITE_SELECT,
    input  logic [WIDTH-1:0]  IMEM_INPUT,
    input  logic              WRITE_VALID,
    output logic              WRITE_READY,
    input  logic              RELOAD,
    output logic              BUSY,
    output logic              LOAD_DONE
);

    localparam int                DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    state_t            state, state_nx;
    logic [ADDR_W-1:0] load_cnt;
    logic              load_done_q;
    logic [WIDTH-1:0]  rom_word;
    logic              write_fire;
    logic              load_last;

    imem_init_rom #(
        .ADDR_W   (ADDR_W),
        .WIDTH    (WIDTH),
        .INIT_SEL (INIT_SEL)
    ) u_rom (
        .addr (load_cnt),
        .word (rom_word)
    );

    // Handshake: a word is written only on an edge where WRITE_VALID and
    // WRITE_READY are both high; READY drops combinationally with RELOAD so a
    // write racing a reload request never lands.
    assign BUSY        = (state == LOAD);
    assign WRITE_READY = (state == RUN) & ~RELOAD;
    assign write_fire  = WRITE_VALID & WRITE_READY;
    assign load_last   = (state == LOAD) && (load_cnt == LAST);
    assign IMEM_OUTPUT = mem[READ_SELECT];
    assign LOAD_DONE   = load_done_q;

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (load_cnt == LAST) state_nx = RUN;
            RUN:     if (RELOAD) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= LOAD;
            load_cnt    <= '0;
            load_done_q <= 1'b0;
        end else begin
            state       <= state_nx;
            load_done_q <= load_last;
            if (state == LOAD) begin
                load_cnt <= load_last ? '0 : load_cnt + 1'b1;
            end else if (RELOAD) begin
                load_cnt <= '0;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == LOAD) begin
            mem[load_cnt] <= rom_word;
        end else if (write_fire) begin
            mem[WRITE_SELECT] <= IMEM_INPUT;
        end
    end

endmodule

// File: tb/tb_imem_bank_param.sv
// Bench for imem_bank_param (WIDTH=16, ADDR_W=4): image-1 bank plus an
// all-zero image bank sharing the same stimulus.
module tb_imem_bank_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  rd_sel;
  logic [3:0]  wr_sel;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        reload;

  logic [15:0] out1, out0;
  logic        ready1, ready0, busy1, busy0, ld1, ld0;

  imem_bank_param #(.WIDTH(16), .ADDR_W(4), .INIT_SEL(1)) dut (
    .CLOCK        (clk),
    .RESET        (rst),
    .READ_SELECT  (rd_sel),
    .IMEM_OUTPUT  (out1),
    .WRITE_SELECT (wr_sel),
    .IMEM_INPUT   (wr_data),
    .WRITE_VALID  (wr_valid),
    .WRITE_READY  (ready1),
    .RELOAD       (reload),
    .BUSY         (busy1),
    .LOAD_DONE    (ld1)
  );

  imem_bank_param #(.WIDTH(16), .ADDR_W(4), .INIT_SEL(0)) dut0 (
    .CLOCK        (clk),
    .RESET        (rst),
    .READ_SELECT  (rd_sel),
    .IMEM_OUTPUT  (out0),
    .WRITE_SELECT (wr_sel),
    .IMEM_INPUT   (wr_data),
    .WRITE_VALID  (1'b0),
    .WRITE_READY  (ready0),
    .RELOAD       (1'b0),
    .BUSY         (busy0),
    .LOAD_DONE    (ld0)
  );

  // Hand-written copy of image 1.
  logic [15:0] img [16] = '{
    16'h8100, 16'h8201, 16'h2412, 16'h9300,
    16'hA003, 16'h3C12, 16'hD805, 16'hE402,
    16'h4507, 16'h1B2C, 16'hC0DE, 16'h7F01,
    16'h5A5A, 16'h6E0F, 16'hF00D, 16'h0FF0
  };

  // ---------------- scoreboard ----------------
  localparam int K_OUT1 = 0, K_BUSY = 1, K_READY = 2, K_LD = 3, K_OUT0 = 4, K_LD0 = 5;

  logic [15:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic expect_val(input int kind, input logic [15:0] v, input string name);
    exp_q.push_back(v);
    kind_q.push_back(kind);
    name_q.push_back(name);
  endtask

  task automatic expect_flags(input logic b, input logic r, input logic l, input string name);
    expect_val(K_BUSY,  {15'd0, b}, {name, "_busy"});
    expect_val(K_READY, {15'd0, r}, {name, "_ready"});
    expect_val(K_LD,    {15'd0, l}, {name, "_load_done"});
  endtask

  function automatic logic [15:0] actual(input int kind);
    case (kind)
      K_OUT1:  return out1;
      K_BUSY:  return {15'd0, busy1};
      K_READY: return {15'd0, ready1};
      K_LD:    return {15'd0, ld1};
      K_OUT0:  return out0;
      K_LD0:   return {15'd0, ld0};
      default: return 16'hxxxx;
    endcase
  endfunction

  // Monitor: compares every queued expectation mid-cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [15:0] e, a;
      int          k;
      string       nm;
      e  = exp_q.pop_front();
      k  = kind_q.pop_front();
      nm = name_q.pop_front();
      a  = actual(k);
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h (t=%0t)", nm, a, e, $time);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    rd_sel   = '0;
    wr_sel   = '0;
    wr_data  = '0;
    wr_valid = 1'b0;
    reload   = 1'b0;
    step();

    // Reset state, then first load from reset.
    rst    = 1'b0;
    rd_sel = 4'd5;
    expect_val(K_OUT1, 16'h0000, "reset_word5");
    expect_flags(1'b1, 1'b0, 1'b0, "reset");
    step();
    for (int k = 1; k <= 16; k++) begin
      rd_sel = 4'(k - 1);
      expect_val(K_OUT1, img[k-1], $sformatf("load_word%0d", k - 1));
      expect_flags(k < 16, k == 16, k == 16, $sformatf("load_c%0d", k));
      if (k == 16) expect_val(K_LD0, 16'd1, "zero_img_load_done");
      step();
    end
    expect_val(K_LD, 16'd0, "load_done_one_cycle");
    step();
    for (int i = 0; i < 16; i++) begin
      rd_sel = 4'(i);
      expect_val(K_OUT1, img[i], $sformatf("sweep_word%0d", i));
      step();
    end

    // Programming write in RUN; old value visible during the write cycle.
    rd_sel   = 4'd5;
    wr_valid = 1'b1;
    wr_sel   = 4'd5;
    wr_data  = 16'hA5A5;
    expect_val(K_READY, 16'd1, "run_ready");
    expect_val(K_OUT1, img[5], "write_cycle_old_value");
    step();
    wr_valid = 1'b0;
    expect_val(K_OUT1, 16'hA5A5, "write_landed");
    step();

    // Reset at load cycle 7, with WRITE_VALID held through the reload.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) step();
    rd_sel = 4'd3;
    expect_val(K_OUT1, img[3], "mid_load_word3");
    rst = 1'b1;
    step();
    rst      = 1'b0;
    wr_valid = 1'b1;
    wr_sel   = 4'd9;
    wr_data  = 16'hBEEF;
    expect_val(K_OUT1, 16'h0000, "rst_mid_word3_zero");
    expect_flags(1'b1, 1'b0, 1'b0, "rst_mid");
    step();
    rd_sel = 4'd5;
    expect_val(K_OUT1, 16'h0000, "rst_mid_word5_zero");
    step();
    for (int k = 2; k <= 16; k++) begin
      rd_sel = 4'(k - 1);
      expect_val(K_OUT1, img[k-1], $sformatf("reload_rst_word%0d", k - 1));
      expect_flags(k < 16, k == 16, k == 16, $sformatf("reload_rst_c%0d", k));
      step();
    end
    wr_valid = 1'b0;
    rd_sel   = 4'd9;
    expect_val(K_OUT1, 16'hBEEF, "held_write_landed");
    step();
    rd_sel = 4'd8;
    expect_val(K_OUT1, img[8], "held_write_single");
    step();

    // RELOAD with a racing write to word 3: write must be dropped.
    reload   = 1'b1;
    wr_valid = 1'b1;
    wr_sel   = 4'd3;
    wr_data  = 16'h1234;
    rd_sel   = 4'd3;
    expect_val(K_READY, 16'd0, "reload_ready_low");
    expect_val(K_BUSY, 16'd0, "reload_cycle_busy");
    expect_val(K_OUT1, img[3], "reload_cycle_word3");
    step();
    reload   = 1'b0;
    wr_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) begin
        rd_sel = 4'd9;
        expect_val(K_OUT1, 16'hBEEF, "reload_keeps_old_word9");
      end else begin
        rd_sel = 4'(k - 1);
        expect_val(K_OUT1, img[k-1], $sformatf("reload_word%0d", k - 1));
      end
      expect_flags(1'b1, 1'b0, 1'b0, $sformatf("reload_c%0d", k));
      step();
    end
    rd_sel = 4'd9;
    expect_val(K_OUT1, img[9], "reload_word9_restored");
    expect_flags(1'b0, 1'b1, 1'b1, "reload_done");
    step();
    rd_sel = 4'd3;
    expect_val(K_OUT1, img[3], "reload_write_dropped");
    step();

    // All-zero image bank.
    for (int i = 0; i < 16; i++) begin
      rd_sel = 4'(i);
      expect_val(K_OUT0, 16'h0000, $sformatf("zero_img_word%0d", i));
      step();
    end

    step();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
